// File: rtl/uart_pkg.sv
// Shared UART types and constants: receive FSM states, oversampling vote
// positions and the per-frame status flags.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_VOTE_LO    = 7;
    localparam int UART_VOTE_MID   = 8;
    localparam int UART_VOTE_HI    = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_deframe_state_t;

    typedef struct packed {
        logic parity_error;
        logic frame_error;
    } uart_rx_status_t;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: down-counter reloaded from the divisor, one-cycle
// tick at zero. Holding it keeps the phase parked at the divisor value.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             hold,
    input  logic [DIV_W-1:0] baud_div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == '0) && !hold;
        cnt_d = cnt_q - DIV_W'(1);
        if (hold || (cnt_q == '0)) begin
            cnt_d = baud_div;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// 16x oversampling UART receiver with majority voting and a valid/ready output
// register. Parity support is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 16,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rx_en,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              parity_enable,
    input  logic              parity_odd,
    input  logic              stop_bit,
    input  logic              rx_pin,
    input  logic              rx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              parity_error,
    output logic              frame_error,
    output logic              overrun_error,
    input  logic              overrun_clear,
    output logic              busy
);

    localparam int SCNT_W = $clog2(OVERSAMPLE);
    localparam int BCNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [SCNT_W-1:0] V_LO      = SCNT_W'(UART_VOTE_LO);
    localparam logic [SCNT_W-1:0] V_MID     = SCNT_W'(UART_VOTE_MID);
    localparam logic [SCNT_W-1:0] V_HI      = SCNT_W'(UART_VOTE_HI);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_W - 1);

    logic              sync1_q, sync2_q, prev_q;
    rx_deframe_state_t state_q;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [DATA_W-1:0] shift_q, rx_data_q;
    logic [1:0]        samp_q;
    logic              par_err_q, frm_err_q, stop2_q;
    uart_rx_status_t   status_q;
    logic              rx_valid_q, overrun_q;

    logic              tick;
    logic              start_edge;
    logic              bit_v;
    logic              vote_now;
    logic              bit_end;
    logic              take;
    logic              par_mismatch;
    rx_deframe_state_t after_data;

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clock    (clock),
        .reset_n  (reset_n),
        .hold     (state_q == ST_IDLE),
        .baud_div (baud_div),
        .tick     (tick)
    );

    // The third vote is the live synchronized pin at the last vote position.
    assign start_edge = prev_q & ~sync2_q;
    assign bit_v      = majority3({samp_q, sync2_q});
    assign vote_now   = tick && (scnt_q == V_HI);
    assign bit_end    = tick && (scnt_q == SCNT_LAST);
    assign scnt_d     = scnt_q + SCNT_W'(1);
    assign bcnt_d     = bcnt_q + BCNT_W'(1);
    assign take       = ~rx_valid_q | rx_ready;

`ifdef UART_RX_PARITY_EN
    assign after_data   = parity_enable ? ST_PARITY : ST_STOP;
    assign par_mismatch = bit_v ^ (^shift_q) ^ parity_odd;
    assign parity_error = status_q.parity_error;
`else
    logic unused_parity;
    assign after_data    = ST_STOP;
    assign par_mismatch  = 1'b0;
    assign parity_error  = 1'b0;
    assign unused_parity = parity_enable ^ parity_odd ^ status_q.parity_error ^ par_mismatch;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            state_q    <= ST_IDLE;
            scnt_q     <= '0;
            bcnt_q     <= '0;
            shift_q    <= '0;
            samp_q     <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            stop2_q    <= 1'b0;
            rx_data_q  <= '0;
            status_q   <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            sync1_q <= rx_pin;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;

            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            if (overrun_clear) begin
                overrun_q <= 1'b0;
            end

            if (!rx_en) begin
                state_q <= ST_IDLE;
                scnt_q  <= '0;
                bcnt_q  <= '0;
                stop2_q <= 1'b0;
            end else begin
                if (tick && (state_q != ST_IDLE)) begin
                    scnt_q <= scnt_d;
                    if (scnt_q == V_LO) begin
                        samp_q[0] <= sync2_q;
                    end
                    if (scnt_q == V_MID) begin
                        samp_q[1] <= sync2_q;
                    end
                end

                unique case (state_q)
                    ST_IDLE: begin
                        scnt_q <= '0;
                        bcnt_q <= '0;
                        if (start_edge) begin
                            state_q   <= ST_START;
                            par_err_q <= 1'b0;
                            frm_err_q <= 1'b0;
                            stop2_q   <= 1'b0;
                        end
                    end
                    ST_START: begin
                        if (vote_now && bit_v) begin
                            state_q <= ST_IDLE;
                        end else if (bit_end) begin
                            state_q <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (vote_now) begin
                            shift_q <= {bit_v, shift_q[DATA_W-1:1]};
                        end
                        if (bit_end) begin
                            if (bcnt_q == BCNT_LAST) begin
                                bcnt_q  <= '0;
                                state_q <= after_data;
                            end else begin
                                bcnt_q <= bcnt_d;
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    ST_PARITY: begin
                        if (vote_now && par_mismatch) begin
                            par_err_q <= 1'b1;
                        end
                        if (bit_end) begin
                            state_q <= ST_STOP;
                        end
                    end
`endif
                    ST_STOP: begin
                        // Finish at the vote of the last stop bit so the next start edge is caught.
                        if (vote_now) begin
                            if (stop_bit && !stop2_q) begin
                                stop2_q <= 1'b1;
                                if (!bit_v) begin
                                    frm_err_q <= 1'b1;
                                end
                            end else begin
                                state_q <= ST_IDLE;
                                if (take) begin
                                    rx_data_q             <= shift_q;
                                    status_q.parity_error <= par_err_q;
                                    status_q.frame_error  <= frm_err_q | ~bit_v;
                                    rx_valid_q            <= 1'b1;
                                end else begin
                                    overrun_q <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign frame_error   = status_q.frame_error;
    assign overrun_error = overrun_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: a table of frames with hand-computed
// results, plus sequences for latency, glitches, overrun, disable and reset.
module tb_uart_rx_deframer;

    localparam int DATA_W = 8;
    localparam int DIV_W  = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset_n;
    logic              rx_en;
    logic [DIV_W-1:0]  baud_div;
    logic              parity_enable;
    logic              parity_odd;
    logic              stop_bit;
    logic              rx_pin;
    logic              rx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              parity_error;
    logic              frame_error;
    logic              overrun_error;
    logic              overrun_clear;
    logic              busy;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    uart_rx_deframer #(
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .rx_en         (rx_en),
        .baud_div      (baud_div),
        .parity_enable (parity_enable),
        .parity_odd    (parity_odd),
        .stop_bit      (stop_bit),
        .rx_pin        (rx_pin),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .parity_error  (parity_error),
        .frame_error   (frame_error),
        .overrun_error (overrun_error),
        .overrun_clear (overrun_clear),
        .busy          (busy)
    );

    typedef struct {
        logic [7:0] data;
        int         baud;
        bit         par_en;
        bit         par_odd;
        logic       par_bit;
        bit         two_stop;
        logic [1:0] stops;     // [0] first stop bit, [1] second stop bit
        logic [7:0] exp_data;
        bit         exp_perr;
        bit         exp_ferr;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int p);
        rx_pin = v;
        repeat (p) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit with_par, input logic pbit,
                              input bit two_stop, input logic [1:0] stops, input int baud);
        int p;
        p = 16 * (baud + 1);
        drive_bit(1'b0, p);
        for (int b = 0; b < 8; b++) drive_bit(d[b], p);
        if (with_par) drive_bit(pbit, p);
        drive_bit(stops[0], p);
        if (two_stop) drive_bit(stops[1], p);
        rx_pin = 1'b1;
    endtask

    task automatic consume(input string name);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        check(name, rx_valid, 1'b0);
    endtask

    initial begin
        int  n;
        bit  saw_busy;

        vecs[0]  = '{8'hA5, 1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0};
        vecs[1]  = '{8'h03, 1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 8'h03, 1'b1, 1'b0};
        vecs[2]  = '{8'h03, 1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 8'h03, 1'b0, 1'b0};
        vecs[3]  = '{8'h5A, 1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 8'h5A, 1'b0, 1'b1};
        vecs[4]  = '{8'h81, 1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 8'h81, 1'b0, 1'b1};
        vecs[5]  = '{8'hFF, 1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 8'hFF, 1'b0, 1'b0};
        vecs[6]  = '{8'h00, 1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{8'h7E, 0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 8'h7E, 1'b1, 1'b0};
        vecs[8]  = '{8'hC4, 2, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 8'hC4, 1'b0, 1'b0};
        vecs[9]  = '{8'h3C, 0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 8'h3C, 1'b0, 1'b1};
        vecs[10] = '{8'h96, 3, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 8'h96, 1'b1, 1'b0};

        reset_n       = 1'b0;
        rx_en         = 1'b1;
        baud_div      = DIV_W'(1);
        parity_enable = 1'b0;
        parity_odd    = 1'b0;
        stop_bit      = 1'b0;
        rx_pin        = 1'b1;
        rx_ready      = 1'b0;
        overrun_clear = 1'b0;

        // Reset state
        idle(3);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_parity_error", parity_error, 1'b0);
        check("reset_frame_error", frame_error, 1'b0);
        check("reset_overrun", overrun_error, 1'b0);
        check("reset_busy", busy, 1'b0);
        reset_n = 1'b1;
        idle(4);

        // First-frame latency: three input flops, then 154 ticks of two clocks
        // from entering START to the vote in the stop bit, about 9.5 bit times.
        n = 0;
        fork
            send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 2'b11, 1);
            begin
                while (!rx_valid && n < 400) begin
                    @(posedge clock);
                    #1;
                    n++;
                end
            end
        join
        checks++;
        if (n < 304 || n > 312) begin
            errors++;
            $display("FAIL latency: got %0d clocks, want 304..312", n);
        end
        $display("latency frame: data=%02h after %0d clocks", rx_data, n);
        check("latency_data", rx_data, 8'hA5);
        check("latency_perr", parity_error, 1'b0);
        check("latency_ferr", frame_error, 1'b0);
        consume("latency_consume");
        idle(4);

        // Table of frames
        for (int i = 0; i < NV; i++) begin
            baud_div      = DIV_W'(vecs[i].baud);
            parity_enable = vecs[i].par_en;
            parity_odd    = vecs[i].par_odd;
            stop_bit      = vecs[i].two_stop;
            send_frame(vecs[i].data, vecs[i].par_en & PAR_BUILT, vecs[i].par_bit,
                       vecs[i].two_stop, vecs[i].stops, vecs[i].baud);
            idle(4);
            $display("vec %0d: sent=%02h got=%02h valid=%0b perr=%0b ferr=%0b busy=%0b",
                     i, vecs[i].data, rx_data, rx_valid, parity_error, frame_error, busy);
            check($sformatf("vec%0d_valid", i), rx_valid, 1'b1);
            check($sformatf("vec%0d_data", i), rx_data, vecs[i].exp_data);
            check($sformatf("vec%0d_perr", i), parity_error, PAR_BUILT ? vecs[i].exp_perr : 1'b0);
            check($sformatf("vec%0d_ferr", i), frame_error, vecs[i].exp_ferr);
            check($sformatf("vec%0d_busy", i), busy, 1'b0);
            consume($sformatf("vec%0d_consume", i));
            idle(2);
        end

        // Five-clock low glitch: START is entered, the vote rejects it
        baud_div      = DIV_W'(0);
        parity_enable = 1'b0;
        stop_bit      = 1'b0;
        saw_busy      = 1'b0;
        rx_pin        = 1'b0;
        idle(5);
        rx_pin = 1'b1;
        for (int c = 0; c < 40; c++) begin
            idle(1);
            if (busy) saw_busy = 1'b1;
        end
        $display("glitch: saw_busy=%0b busy=%0b valid=%0b", saw_busy, busy, rx_valid);
        check("glitch_saw_busy", saw_busy, 1'b1);
        check("glitch_busy_end", busy, 1'b0);
        check("glitch_no_valid", rx_valid, 1'b0);

        // Overrun: two back-to-back frames with the FIFO full
        baud_div = DIV_W'(1);
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 2'b11, 1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 2'b11, 1);
        idle(4);
        $display("overrun: data=%02h valid=%0b overrun=%0b", rx_data, rx_valid, overrun_error);
        check("overrun_valid", rx_valid, 1'b1);
        check("overrun_data", rx_data, 8'h11);
        check("overrun_flag", overrun_error, 1'b1);
        overrun_clear = 1'b1;
        idle(1);
        overrun_clear = 1'b0;
        check("overrun_cleared", overrun_error, 1'b0);
        check("overrun_data_kept", rx_data, 8'h11);
        consume("overrun_consume");
        idle(2);

        // Disable mid-frame: partial frame dropped, held byte untouched
        send_frame(8'h42, 1'b0, 1'b0, 1'b0, 2'b11, 1);
        idle(4);
        drive_bit(1'b0, 32);
        drive_bit(1'b1, 32);
        drive_bit(1'b1, 32);
        check("disable_busy_before", busy, 1'b1);
        rx_en = 1'b0;
        idle(1);
        $display("disable: busy=%0b data=%02h valid=%0b", busy, rx_data, rx_valid);
        check("disable_busy_after", busy, 1'b0);
        check("disable_data_kept", rx_data, 8'h42);
        check("disable_valid_kept", rx_valid, 1'b1);
        rx_pin = 1'b1;
        idle(64);
        rx_en = 1'b1;
        idle(4);
        check("disable_no_frame", busy, 1'b0);
        consume("disable_consume");
        idle(2);

        // Asynchronous reset mid-DATA with a byte held
        send_frame(8'h5C, 1'b0, 1'b0, 1'b0, 2'b11, 1);
        idle(4);
        check("areset_held_valid", rx_valid, 1'b1);
        drive_bit(1'b0, 32);
        drive_bit(1'b0, 32);
        drive_bit(1'b1, 32);
        #3;
        reset_n = 1'b0;
        #1;
        $display("async reset: valid=%0b data=%02h busy=%0b ferr=%0b", rx_valid, rx_data, busy, frame_error);
        check("areset_valid", rx_valid, 1'b0);
        check("areset_data", rx_data, 8'h00);
        check("areset_busy", busy, 1'b0);
        check("areset_ferr", frame_error, 1'b0);
        rx_pin = 1'b1;
        idle(3);
        reset_n = 1'b1;
        idle(4);
        send_frame(8'h96, 1'b0, 1'b0, 1'b0, 2'b11, 1);
        idle(4);
        $display("after reset: data=%02h valid=%0b", rx_data, rx_valid);
        check("post_reset_valid", rx_valid, 1'b1);
        check("post_reset_data", rx_data, 8'h96);
        check("post_reset_ferr", frame_error, 1'b0);
        consume("post_reset_consume");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
